frame_scrambler_tx: RTL and testbench

- Transmit-side framer and scrambler for the digital link; it is the TX counterpart of the RX frame-sync/descrambler chain.
- On a start request it serialises a fixed sync word (unscrambled), then PAYLOAD_LEN payload bits scrambled with an 8-bit additive LFSR (seed LFSR_SEED, taps 0,2,4,7).
- Output is one bit per baud strobe, feeding the modulator.

---
 rtl/frame_scrambler_tx.sv | 106 ++++++++++
 tb/tb_frame_scrambler_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scrambler_tx.sv
// Transmit framer: sends an unscrambled sync word, then PAYLOAD_LEN payload bits
// scrambled with an 8-bit additive LFSR. One output bit per baud strobe, 1-clk latency.
module frame_scrambler_tx #(
    parameter int unsigned SYNC_LEN    = 16,
    parameter logic [31:0] SYNC_WORD   = 32'h0000_EB90,
    parameter int unsigned PAYLOAD_LEN = 64,
    parameter logic [7:0]  LFSR_SEED   = 8'hAA
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_abort,
    input  logic i_bit_en,
    input  logic i_data,
    input  logic i_valid,
    output logic o_ready,
    output logic o_tx_data,
    output logic o_tx_valid,
    output logic o_sync_done,
    output logic o_end_pulse,
    output logic o_underrun,
    output logic o_busy
);
    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        SYNC    = 3'b010,
        PAYLOAD = 3'b100
    } state_t;

    localparam logic [15:0] SYNC_LAST = 16'(SYNC_LEN - 1);
    localparam logic [15:0] PAY_LAST  = 16'(PAYLOAD_LEN - 1);

    state_t      state;
    logic [7:0]  lfsr;
    logic [15:0] cnt;
    logic [4:0]  sync_idx;
    logic        lfsr_fb;

    // cnt never exceeds SYNC_LEN-1 (<=31) while in SYNC, so 5 bits index the word
    assign sync_idx = 5'(SYNC_LEN - 1) - cnt[4:0];
    assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[4] ^ lfsr[7];
    assign o_ready  = (state == PAYLOAD) && i_bit_en;
    assign o_busy   = (state == SYNC) || (state == PAYLOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            cnt         <= '0;
            o_tx_data   <= 1'b0;
            o_tx_valid  <= 1'b0;
            o_sync_done <= 1'b0;
            o_end_pulse <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            o_tx_valid  <= 1'b0;
            o_sync_done <= 1'b0;
            o_end_pulse <= 1'b0;
            o_underrun  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        lfsr  <= LFSR_SEED;
                        cnt   <= '0;
                        state <= SYNC;
                    end
                end
                SYNC: begin
                    if (i_abort) begin
                        state <= IDLE;
                    end else if (i_bit_en) begin
                        o_tx_data  <= SYNC_WORD[sync_idx];
                        o_tx_valid <= 1'b1;
                        if (cnt == SYNC_LAST) begin
                            o_sync_done <= 1'b1;
                            cnt         <= '0;
                            state       <= PAYLOAD;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (i_abort) begin
                        state <= IDLE;
                    end else if (i_bit_en && i_valid) begin
                        o_tx_data  <= i_data ^ lfsr[7];
                        o_tx_valid <= 1'b1;
                        lfsr       <= {lfsr[6:0], lfsr_fb};
                        if (cnt == PAY_LAST) begin
                            o_end_pulse <= 1'b1;
                            cnt         <= '0;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end else if (i_bit_en) begin
                        // skipped slot: lfsr and cnt hold so the far-end descrambler stays aligned
                        o_underrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_scrambler_tx.sv
// Bench for frame_scrambler_tx: cycle scoreboard against a reference model plus
// table-driven checks on the captured serial stream.
module tb_frame_scrambler_tx;
    logic clk = 1'b0;
    logic rst, i_start, i_abort, i_bit_en, i_data, i_valid;
    logic o_ready, o_tx_data, o_tx_valid, o_sync_done, o_end_pulse, o_underrun, o_busy;

    frame_scrambler_tx dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_bit_en(i_bit_en), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
        .o_sync_done(o_sync_done), .o_end_pulse(o_end_pulse),
        .o_underrun(o_underrun), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic dat;
        logic vld;
        logic sd;
        logic ep;
        logic ur;
        logic busy;
    } out_t;

    typedef struct {
        int   idx;
        logic dat;
        logic sd;
        logic ep;
        logic chk_dat;
    } vec_t;

    int errors = 0;
    int checks = 0;
    out_t exp_q[$];

    // reference model state: 0 idle, 1 sync, 2 payload
    int         ms = 0;
    int         mc = 0;
    logic [7:0] ml = 8'hAA;
    logic [15:0] sw = 16'hEB90;

    logic lg_dat[$];
    logic lg_sd[$];
    logic lg_ep[$];
    int   n_ur;

    vec_t        tbl[25];
    logic [23:0] nom_bits = 24'b1110_1011_1001_0000_1010_1010;
    logic [63:0] nom_pay, pl, rec, got;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        lg_dat.delete();
        lg_sd.delete();
        lg_ep.delete();
        n_ur = 0;
    endtask

    task automatic step(input logic st, input logic ab, input logic be,
                        input logic d, input logic v, input logic r);
        out_t e, a;
        rst = r; i_start = st; i_abort = ab; i_bit_en = be; i_data = d; i_valid = v;
        @(negedge clk);
        chk("ready", 64'(o_ready), 64'((ms == 2) && be));
        e = '0;
        if (r) begin
            ms = 0; mc = 0; ml = 8'hAA;
        end else begin
            case (ms)
                0: if (st) begin ml = 8'hAA; mc = 0; ms = 1; end
                1: if (ab) ms = 0;
                   else if (be) begin
                       e.vld = 1'b1;
                       e.dat = sw[15 - mc];
                       if (mc == 15) begin e.sd = 1'b1; mc = 0; ms = 2; end
                       else mc++;
                   end
                default: if (ab) ms = 0;
                   else if (be && v) begin
                       e.vld = 1'b1;
                       e.dat = d ^ ml[7];
                       ml = {ml[6:0], ml[0] ^ ml[2] ^ ml[4] ^ ml[7]};
                       if (mc == 63) begin e.ep = 1'b1; mc = 0; ms = 0; end
                       else mc++;
                   end else if (be) e.ur = 1'b1;
            endcase
        end
        e.busy = (ms != 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a.dat  = o_tx_valid & o_tx_data;
        a.vld  = o_tx_valid;
        a.sd   = o_sync_done;
        a.ep   = o_end_pulse;
        a.ur   = o_underrun;
        a.busy = o_busy;
        chk("outputs", 64'(a), 64'(exp_q.pop_front()));
        if (o_tx_valid) begin
            lg_dat.push_back(o_tx_data);
            lg_sd.push_back(o_sync_done);
            lg_ep.push_back(o_end_pulse);
        end
        if (o_underrun) n_ur++;
    endtask

    function automatic int count_ep();
        int n = 0;
        foreach (lg_ep[k]) if (lg_ep[k]) n++;
        return n;
    endfunction

    function automatic logic [63:0] payload_bits();
        logic [63:0] p = '0;
        for (int k = 0; k < 64; k++)
            if (16 + k < lg_dat.size()) p[k] = lg_dat[16 + k];
        return p;
    endfunction

    function automatic logic [15:0] sync_bits();
        logic [15:0] s = '0;
        for (int k = 0; k < 16; k++)
            if (k < lg_dat.size()) s[15 - k] = lg_dat[k];
        return s;
    endfunction

    initial begin
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_bit_en = 1'b0; i_data = 1'b0; i_valid = 1'b0;
        n_ur = 0;
        for (int i = 0; i < 24; i++) tbl[i] = '{i, nom_bits[23 - i], (i == 15), 1'b0, 1'b1};
        tbl[24] = '{79, 1'b0, 1'b0, 1'b1, 1'b0};

        // reset
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 1, 1);
        chk("rst_tx_data", 64'(o_tx_data), 0);
        chk("rst_busy", 64'(o_busy), 0);

        // nominal frame; start and strobe share the first cycle
        clr();
        step(1, 0, 1, 0, 1, 0);
        for (int i = 0; i < 80; i++) begin
            step(0, 0, 1, 0, 1, 0);
            if (i == 23) chk("lfsr_after_8", 64'(dut.lfsr), 64'h C7);
        end
        chk("nom_count", lg_dat.size(), 80);
        for (int k = 0; k < 25; k++) begin
            if (tbl[k].idx >= lg_dat.size()) chk("tbl_len", lg_dat.size(), tbl[k].idx + 1);
            else begin
                chk($sformatf("tbl_flags%0d", tbl[k].idx),
                    {lg_sd[tbl[k].idx], lg_ep[tbl[k].idx]}, {tbl[k].sd, tbl[k].ep});
                if (tbl[k].chk_dat)
                    chk($sformatf("tbl_bit%0d", tbl[k].idx), 64'(lg_dat[tbl[k].idx]), 64'(tbl[k].dat));
            end
        end
        nom_pay = payload_bits();
        step(0, 0, 1, 0, 1, 0);
        chk("nom_busy_after", 64'(o_busy), 0);

        // loopback through a descrambler reseeded on sync_done
        clr();
        for (int i = 0; i < 64; i++) pl[i] = 1'($urandom_range(0, 1));
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 80; c++) step(0, 0, 1, (c >= 16) ? pl[c - 16] : 1'b0, 1, 0);
        begin
            logic [7:0] rl = 8'hAA;
            int n = 0;
            logic on = 1'b0;
            rec = '0;
            foreach (lg_dat[k]) begin
                if (on && n < 64) begin
                    rec[n] = lg_dat[k] ^ rl[7];
                    rl = {rl[6:0], rl[0] ^ rl[2] ^ rl[4] ^ rl[7]};
                    n++;
                end
                if (lg_sd[k]) begin on = 1'b1; rl = 8'hAA; end
            end
            chk("loop_n", n, 64);
        end
        chk("loopback", rec, pl);

        // underrun on payload slots 5 and 6
        clr();
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 16; c++) step(0, 0, 1, 0, 1, 0);
        for (int s = 0; s < 66; s++) step(0, 0, 1, 0, !(s == 5 || s == 6), 0);
        chk("ur_pulses", n_ur, 2);
        chk("ur_count", lg_dat.size(), 80);
        chk("ur_payload", payload_bits(), nom_pay);
        chk("ur_ep", count_ep(), 1);

        // baud gating: strobe every 4th cycle
        clr();
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 320; c++) step(0, 0, (c % 4 == 0), 0, 1, 0);
        chk("gate_count", lg_dat.size(), 80);
        chk("gate_ep", count_ep(), 1);

        // abort at payload bit 10, then restart
        clr();
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 26; c++) step(0, 0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        chk("abort_busy", 64'(o_busy), 0);
        chk("abort_count", lg_dat.size(), 26);
        chk("abort_ep", count_ep(), 0);
        step(0, 0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        clr();
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 17; c++) step(0, 0, 1, 0, 1, 0);
        chk("restart_sync", sync_bits(), 16'hEB90);
        chk("restart_first", (lg_dat.size() > 16) ? 64'(lg_dat[16]) : 64'hX, 1);
        step(0, 1, 0, 0, 0, 0);

        // reset at sync bit 7
        clr();
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 7; c++) step(0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 1);
        chk("rst_mid_valid", 64'(o_tx_valid), 0);
        chk("rst_mid_busy", 64'(o_busy), 0);
        chk("rst_mid_count", lg_dat.size(), 7);

        // start while busy is ignored
        clr();
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 80; c++) step((c == 36), 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        chk("busy_start_count", lg_dat.size(), 80);
        chk("busy_start_ep", count_ep(), 1);
        chk("busy_start_payload", payload_bits(), nom_pay);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
